pipelined_barrel_shifter: RTL

// - Parametrised, pipelined shifter for the ALU datapath; generalises the fixed

---
 rtl/pipelined_barrel_shifter.sv | 91 +++++++++
 1 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Log2-stage pipelined barrel shifter (SLL/SRL/SRA, optional ROL) with valid/ready flow control.
// Define SHIFTER_ROTATE_EN to make op 2'b11 a rotate-left; otherwise op 2'b11 passes data through.
module pipelined_barrel_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    // One stage: shift by 2^k when en is set. SRA keeps replicating the current MSB,
    // which is still the operand's original sign bit at every stage.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic             en,
        input int               k
    );
        logic signed [WIDTH-1:0] sd;
        int                      amt;
        sd  = d;
        amt = en ? (1 << k) : 0;
        case (op)
            OP_SLL:  shift_stage = d << amt;
            OP_SRL:  shift_stage = d >> amt;
            OP_SRA:  shift_stage = sd >>> amt;
`ifdef SHIFTER_ROTATE_EN
            default: shift_stage = (d << amt) | (d >> (WIDTH - amt));
`else
            default: shift_stage = d;
`endif
        endcase
    endfunction

    logic               vld_p   [SHAMT_W];
    logic [WIDTH-1:0]   data_p  [SHAMT_W];
    logic [SHAMT_W-1:0] shamt_p [SHAMT_W];
    logic [1:0]         op_p    [SHAMT_W];
    logic               adv;
    logic               unused_ctl;

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p[SHAMT_W-1];
    assign out_data  = data_p[SHAMT_W-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                vld_p[k]   <= 1'b0;
                data_p[k]  <= '0;
                shamt_p[k] <= '0;
                op_p[k]    <= 2'b00;
            end
        end else if (adv) begin
            // stage 0: consumes shamt bit 0
            vld_p[0]   <= in_valid;
            data_p[0]  <= shift_stage(in_data, in_op, in_shamt[0], 0);
            shamt_p[0] <= in_shamt;
            op_p[0]    <= in_op;
            // stages 1..SHAMT_W-1: stage k consumes shamt bit k
            for (int k = 1; k < SHAMT_W; k++) begin
                vld_p[k]   <= vld_p[k-1];
                data_p[k]  <= shift_stage(data_p[k-1], op_p[k-1], shamt_p[k-1][k], k);
                shamt_p[k] <= shamt_p[k-1];
                op_p[k]    <= op_p[k-1];
            end
        end
    end

    // Already-consumed shamt bits and the final stage's control travel along but are not read.
    always_comb begin
        unused_ctl = 1'b0;
        for (int k = 0; k < SHAMT_W; k++) begin
            unused_ctl = unused_ctl ^ (^shamt_p[k]) ^ (^op_p[k]);
        end
    end

endmodule
